// File: rtl/axilrd2wbx_if.sv
// rtl/axilrd2wbx_if.sv - AXI-lite read channel and pipelined Wishbone master bundle for axilrd2wbx
interface axilrd2wbx_if #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 28
);
    localparam int AW = C_AXI_ADDR_WIDTH - $clog2(C_AXI_DATA_WIDTH/8);

    logic                          i_axi_arvalid;
    logic                          o_axi_arready;
    logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_araddr;
    logic [2:0]                    i_axi_arprot;
    logic                          o_axi_rvalid;
    logic                          i_axi_rready;
    logic [C_AXI_DATA_WIDTH-1:0]   o_axi_rdata;
    logic [1:0]                    o_axi_rresp;
    logic                          o_wb_cyc;
    logic                          o_wb_stb;
    logic [AW-1:0]                 o_wb_addr;
    logic [C_AXI_DATA_WIDTH/8-1:0] o_wb_sel;
    logic                          i_wb_stall;
    logic                          i_wb_ack;
    logic                          i_wb_err;
    logic [C_AXI_DATA_WIDTH-1:0]   i_wb_data;

    // Bridge side: AXI-lite read slave that masters the Wishbone bus.
    modport slave (
        input  i_axi_arvalid, i_axi_araddr, i_axi_arprot, i_axi_rready,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        output o_axi_arready, o_axi_rvalid, o_axi_rdata, o_axi_rresp,
        output o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_sel
    );

    modport master (
        output i_axi_arvalid, i_axi_araddr, i_axi_arprot, i_axi_rready,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        input  o_axi_arready, o_axi_rvalid, o_axi_rdata, o_axi_rresp,
        input  o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_sel
    );
endinterface

// File: rtl/axilrd2wbx.sv
// rtl/axilrd2wbx.sv - AXI-lite read to pipelined Wishbone bridge with in-order response FIFO
module axilrd2wbx #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int LGFIFO           = 3,
    parameter int OPT_TIMEOUT      = 0
) (
    input  logic          i_clk,
    input  logic          i_axi_reset_n,
    axilrd2wbx_if.slave   bus,
    output logic          o_timeout
);
    localparam int DW   = C_AXI_DATA_WIDTH;
    localparam int LSB  = $clog2(DW/8);
    localparam int AW   = C_AXI_ADDR_WIDTH - LSB;
    localparam int FLEN = 1 << LGFIFO;
    localparam logic [LGFIFO:0] FLEN_C = (LGFIFO+1)'(FLEN);

    typedef enum logic {S_RUN, S_FLUSH} state_t;
    state_t state_q, state_d;

    logic              ready_en;
    logic [LGFIFO:0]   inflight, pending, wb_outstanding, wr_ptr, rd_ptr;
    logic [DW+1:0]     mem [FLEN];
    logic              flushing, ar_hs, r_hs, stb_acc, ack_v, err_v, tmo_fire, err_evt;
    logic              wr_evt, out_load, fifo_empty, bypass, fifo_push, fifo_pop;
    logic [DW+1:0]     wr_word;
    wire               unused_ok = &{1'b0, bus.i_axi_arprot, bus.i_axi_araddr[LSB-1:0]};

    assign flushing = (state_q == S_FLUSH);
    assign bus.o_axi_arready = ready_en && !flushing && (inflight < FLEN_C)
                               && (!bus.o_wb_stb || !bus.i_wb_stall);
    assign ar_hs    = bus.i_axi_arvalid && bus.o_axi_arready;
    assign r_hs     = bus.o_axi_rvalid && bus.i_axi_rready;
    assign stb_acc  = bus.o_wb_stb && !bus.i_wb_stall;
    assign ack_v    = bus.o_wb_cyc && bus.i_wb_ack;
    assign err_v    = bus.o_wb_cyc && bus.i_wb_err;
    assign err_evt  = err_v || tmo_fire;
    assign bus.o_wb_cyc = bus.o_wb_stb || (wb_outstanding != '0);
    assign bus.o_wb_sel = '1;

    // pending = accepted requests that have not yet produced a response word;
    // while flushing each one is turned into an SLVERR entry, one per clock.
    assign wr_evt  = ack_v || err_v || (flushing && (pending != '0));
    assign wr_word = (ack_v && !err_v) ? {bus.i_wb_data, 2'b00} : {{DW{1'b0}}, 2'b10};

    // An empty FIFO hands a fresh response straight to the output register.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign out_load   = !bus.o_axi_rvalid || bus.i_axi_rready;
    assign bypass     = out_load && fifo_empty && wr_evt;
    assign fifo_push  = wr_evt && !bypass;
    assign fifo_pop   = out_load && !fifo_empty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (err_evt) state_d = S_FLUSH;
            S_FLUSH: if (inflight == '0) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    generate
        if (OPT_TIMEOUT > 0) begin : g_wd
            localparam int TW = $clog2(OPT_TIMEOUT + 1);
            logic [TW-1:0] wd_cnt;

            assign tmo_fire = bus.o_wb_cyc && !ack_v && !stb_acc
                              && (wd_cnt == TW'(OPT_TIMEOUT - 1));

            always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
                if (!i_axi_reset_n) begin
                    wd_cnt    <= '0;
                    o_timeout <= 1'b0;
                end else begin
                    o_timeout <= tmo_fire;
                    if (!bus.o_wb_cyc || ack_v || stb_acc || err_evt)
                        wd_cnt <= '0;
                    else
                        wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end else begin : g_nowd
            assign tmo_fire  = 1'b0;
            assign o_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            state_q          <= S_RUN;
            ready_en         <= 1'b0;
            inflight         <= '0;
            pending          <= '0;
            wb_outstanding   <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            bus.o_wb_stb     <= 1'b0;
            bus.o_wb_addr    <= '0;
            bus.o_axi_rvalid <= 1'b0;
            bus.o_axi_rdata  <= '0;
            bus.o_axi_rresp  <= 2'b00;
        end else begin
            state_q  <= state_d;
            ready_en <= 1'b1;
            inflight <= inflight + (LGFIFO+1)'(ar_hs) - (LGFIFO+1)'(r_hs);
            pending  <= pending + (LGFIFO+1)'(ar_hs) - (LGFIFO+1)'(wr_evt);

            if (err_evt) begin
                bus.o_wb_stb   <= 1'b0;
                wb_outstanding <= '0;
            end else begin
                if (!bus.o_wb_stb || !bus.i_wb_stall) begin
                    bus.o_wb_stb <= ar_hs;
                    if (ar_hs)
                        bus.o_wb_addr <= bus.i_axi_araddr[C_AXI_ADDR_WIDTH-1:LSB];
                end
                wb_outstanding <= wb_outstanding + (LGFIFO+1)'(stb_acc) - (LGFIFO+1)'(ack_v);
            end

            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;

            if (out_load) begin
                bus.o_axi_rvalid <= !fifo_empty || wr_evt;
                if (!fifo_empty)
                    {bus.o_axi_rdata, bus.o_axi_rresp} <= mem[rd_ptr[LGFIFO-1:0]];
                else if (wr_evt)
                    {bus.o_axi_rdata, bus.o_axi_rresp} <= wr_word;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (fifo_push)
            mem[wr_ptr[LGFIFO-1:0]] <= wr_word;
    end

endmodule

// File: tb/tb_axilrd2wbx.sv
// tb/tb_axilrd2wbx.sv - directed self-checking bench for axilrd2wbx
module tb_axilrd2wbx;
    localparam int DW  = 32;
    localparam int ADW = 28;
    localparam int AW  = 26;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tmo;

    always #5 clk = ~clk;

    axilrd2wbx_if #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(ADW)) bus ();

    axilrd2wbx #(
        .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(ADW), .LGFIFO(3), .OPT_TIMEOUT(16)
    ) dut (
        .i_clk(clk), .i_axi_reset_n(rst_n), .bus(bus), .o_timeout(tmo)
    );

    int n_chk = 0, n_pass = 0;
    int cyc_cnt = 0, ar_acc = 0, ar_blocked = 0, stb_n = 0, first_stb = -1, last_stb = -1;
    int resp_n = 0, err_at = -1, beats_at_ar = -1, ar0 = 0;
    bit ack_en = 1'b1, stray = 1'b0, err_seen = 1'b0;
    logic [ADW-1:0] arq[$];
    logic [AW-1:0]  wbq[$];
    logic [33:0]    rbeats[$];

    function automatic logic [31:0] wb_word(input logic [AW-1:0] a);
        return (a == 26'h4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_ar();
        bus.i_axi_arvalid = (arq.size() > 0);
        bus.i_axi_araddr  = (arq.size() > 0) ? arq[0] : '0;
    endtask

    task automatic offer(input logic [ADW-1:0] addr);
        arq.push_back(addr);
        drive_ar();
    endtask

    task automatic clear_stats();
        ar_blocked = 0; stb_n = 0; first_stb = -1; last_stb = -1;
        resp_n = 0; beats_at_ar = -1;
        rbeats.delete();
    endtask

    // One clock: sample handshakes before the edge, then update AR and WB slave models.
    task automatic tick();
        bit acc, arh;
        logic [AW-1:0] a;
        acc = bus.o_wb_stb && !bus.i_wb_stall;
        a   = bus.o_wb_addr;
        arh = bus.i_axi_arvalid && bus.o_axi_arready;
        if (bus.i_axi_arvalid && !bus.o_axi_arready) ar_blocked++;
        if (bus.o_axi_rvalid && bus.i_axi_rready)
            rbeats.push_back({bus.o_axi_rdata, bus.o_axi_rresp});
        if (arh) beats_at_ar = rbeats.size();
        err_seen = bus.i_wb_err && bus.o_wb_cyc;
        @(posedge clk);
        #1;
        cyc_cnt++;
        if (arh) begin
            ar_acc++;
            void'(arq.pop_front());
        end
        drive_ar();
        if (acc) begin
            wbq.push_back(a);
            stb_n++;
            if (first_stb < 0) first_stb = cyc_cnt;
            last_stb = cyc_cnt;
        end
        if (!bus.o_wb_cyc) wbq.delete();
        bus.i_wb_ack  = stray;
        bus.i_wb_err  = 1'b0;
        bus.i_wb_data = stray ? 32'h5A5A5A5A : 32'h0;
        if (ack_en && wbq.size() > 0) begin
            a = wbq.pop_front();
            if (resp_n == err_at) bus.i_wb_err = 1'b1;
            else begin
                bus.i_wb_ack  = 1'b1;
                bus.i_wb_data = wb_word(a);
            end
            resp_n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got expired expected finished");
        $fatal(1);
    end

    initial begin
        bus.i_axi_arvalid = 1'b0; bus.i_axi_araddr = '0; bus.i_axi_arprot = 3'b0;
        bus.i_axi_rready  = 1'b0; bus.i_wb_stall   = 1'b0; bus.i_wb_ack   = 1'b0;
        bus.i_wb_err      = 1'b0; bus.i_wb_data    = '0;

        // reset state
        #12;
        chk("rst_arready", bus.o_axi_arready, 0);
        chk("rst_stb",     bus.o_wb_stb, 0);
        chk("rst_cyc",     bus.o_wb_cyc, 0);
        chk("rst_rvalid",  bus.o_axi_rvalid, 0);
        chk("rst_rresp",   bus.o_axi_rresp, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_sel",     bus.o_wb_sel, 4'hF);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("arready_after_release", bus.o_axi_arready, 1);

        // single read
        clear_stats();
        bus.i_axi_rready = 1'b1;
        offer(28'h10);
        for (int i = 0; i < 10 && !bus.o_wb_stb; i++) tick();
        chk("single_stb", bus.o_wb_stb, 1);
        chk("single_addr", bus.o_wb_addr, 26'h4);
        for (int i = 0; i < 10 && !bus.i_wb_ack; i++) tick();
        chk("single_ack_seen", bus.i_wb_ack, 1);
        tick();
        chk("single_rvalid", bus.o_axi_rvalid, 1);
        chk("single_rdata", bus.o_axi_rdata, 32'hDEADBEEF);
        chk("single_rresp", bus.o_axi_rresp, 2'b00);
        tick();
        chk("single_beats", rbeats.size(), 1);
        chk("single_rvalid_clear", bus.o_axi_rvalid, 0);

        // burst of 8
        clear_stats();
        for (int i = 0; i < 8; i++) arq.push_back(28'h100 + 28'(4*i));
        drive_ar();
        for (int i = 0; i < 30; i++) tick();
        chk("burst_strobes", stb_n, 8);
        chk("burst_consecutive", last_stb - first_stb, 7);
        chk("burst_ar_blocked", ar_blocked, 0);
        chk("burst_beats", rbeats.size(), 8);
        for (int i = 0; i < 8 && i < rbeats.size(); i++)
            chk($sformatf("burst_beat%0d", i), rbeats[i], {wb_word(26'h40 + 26'(i)), 2'b00});

        // full: 9 offered with rready low
        clear_stats();
        ar0 = ar_acc;
        bus.i_axi_rready = 1'b0;
        for (int i = 0; i < 9; i++) arq.push_back(28'h400 + 28'(4*i));
        drive_ar();
        for (int i = 0; i < 20; i++) tick();
        chk("full_accepted8", ar_acc - ar0, 8);
        chk("full_arready_low", bus.o_axi_arready, 0);
        bus.i_axi_rready = 1'b1;
        tick();
        bus.i_axi_rready = 1'b0;
        chk("full_arready_after_r", bus.o_axi_arready, 1);
        tick();
        chk("full_accepted9", ar_acc - ar0, 9);
        bus.i_axi_rready = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        chk("full_beats", rbeats.size(), 9);
        if (rbeats.size() == 9) begin
            chk("full_beat0", rbeats[0], {wb_word(26'h100), 2'b00});
            chk("full_beat8", rbeats[8], {wb_word(26'h108), 2'b00});
        end

        // error on second ack with 4 in flight
        clear_stats();
        ack_en = 1'b0;
        err_at = 1;
        for (int i = 0; i < 4; i++) arq.push_back(28'h200 + 28'(4*i));
        drive_ar();
        for (int i = 0; i < 8; i++) tick();
        chk("err_strobes", stb_n, 4);
        chk("err_cyc_before", bus.o_wb_cyc, 1);
        ack_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (err_seen) break;
        end
        chk("err_seen", err_seen, 1);
        chk("err_cyc_drop", bus.o_wb_cyc, 0);
        chk("err_arready_low", bus.o_axi_arready, 0);
        err_at = -1;
        offer(28'h210);
        for (int i = 0; i < 30 && rbeats.size() < 5; i++) tick();
        chk("err_beats", rbeats.size(), 5);
        if (rbeats.size() == 5) begin
            chk("err_beat0", rbeats[0], {wb_word(26'h80), 2'b00});
            chk("err_beat1", rbeats[1], {32'h0, 2'b10});
            chk("err_beat2", rbeats[2], {32'h0, 2'b10});
            chk("err_beat3", rbeats[3], {32'h0, 2'b10});
            chk("err_beat4", rbeats[4], {wb_word(26'h84), 2'b00});
        end
        chk("err_ar_after_retire", beats_at_ar >= 4, 1);

        // watchdog with stall held
        clear_stats();
        bus.i_wb_stall = 1'b1;
        offer(28'h300);
        tick();
        chk("tmo_stb", bus.o_wb_stb, 1);
        chk("tmo_addr", bus.o_wb_addr, 26'hC0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 15) begin
                chk("tmo_not_yet", tmo, 0);
                chk("tmo_cyc_held", bus.o_wb_cyc, 1);
            end
            if (k == 16) begin
                chk("tmo_pulse", tmo, 1);
                chk("tmo_cyc_drop", bus.o_wb_cyc, 0);
            end
            if (k == 17) chk("tmo_pulse_end", tmo, 0);
        end
        bus.i_wb_stall = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("tmo_beats", rbeats.size(), 1);
        if (rbeats.size() == 1) chk("tmo_beat", rbeats[0], {32'h0, 2'b10});

        // asynchronous reset with 3 in flight
        clear_stats();
        bus.i_axi_rready = 1'b0;
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) arq.push_back(28'h500 + 28'(4*i));
        drive_ar();
        for (int i = 0; i < 6; i++) tick();
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        tick();
        chk("ar_rst_rvalid_before", bus.o_axi_rvalid, 1);
        chk("ar_rst_cyc_before", bus.o_wb_cyc, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rst_stb", bus.o_wb_stb, 0);
        chk("ar_rst_cyc", bus.o_wb_cyc, 0);
        chk("ar_rst_rvalid", bus.o_axi_rvalid, 0);
        chk("ar_rst_arready", bus.o_axi_arready, 0);
        chk("ar_rst_timeout", tmo, 0);
        #2;
        rst_n = 1'b1;
        bus.i_axi_rready = 1'b1;
        stray = 1'b1;
        bus.i_wb_ack = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        stray = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("stray_no_beat", rbeats.size(), 0);
        chk("stray_rvalid", bus.o_axi_rvalid, 0);
        chk("stray_cyc", bus.o_wb_cyc, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
